// File: rtl/sa_raddr_arbiter.sv
// Per-slave AR arbiter: round-robin over dispatcher requests, one-entry AR output register, in-order {master,len} log.
// Latency: request accepted at edge N appears on s_ARVALID_o after that edge; 1 AR/cycle with back-to-back slave handshakes.
// Backpressure: grant only when output slot is free (empty or draining) and the order FIFO is not full; payload held while stalled.

// Small generic synchronous FIFO with registered count; head is visible combinationally.
module sa_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             full,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    input  logic             rd_pop
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Overflow and underflow are absorbed here so the count stays within 0..DEPTH.
    assign full   = (count == CNT_W'(DEPTH));
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign push   = wr_vld & ~full;
    assign pop    = rd_pop & rd_vld;

    // Storage array, written only on an accepted push; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module sa_raddr_arbiter #(
    parameter int MST_AMT           = 2,
    parameter int OUTSTANDING_AMT   = 8,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int TRANS_BURST_W     = 2,
    parameter int TRANS_DATA_LEN_W  = 3,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter int MST_ID_W          = (MST_AMT > 1) ? $clog2(MST_AMT) : 1
) (
    input  logic                                  ACLK_i,
    input  logic                                  ARESETn_i,
    input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_ARID_i,
    input  logic [ADDR_WIDTH*MST_AMT-1:0]         dsp_ARADDR_i,
    input  logic [TRANS_BURST_W*MST_AMT-1:0]      dsp_ARBURST_i,
    input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   dsp_ARLEN_i,
    input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]  dsp_ARSIZE_i,
    input  logic [MST_AMT-1:0]                    dsp_ARVALID_i,
    output logic [MST_AMT-1:0]                    dsp_ARREADY_o,
    output logic [MST_ID_W+TRANS_MST_ID_W-1:0]    s_ARID_o,
    output logic [ADDR_WIDTH-1:0]                 s_ARADDR_o,
    output logic [TRANS_BURST_W-1:0]              s_ARBURST_o,
    output logic [TRANS_DATA_LEN_W-1:0]           s_ARLEN_o,
    output logic [TRANS_DATA_SIZE_W-1:0]          s_ARSIZE_o,
    output logic                                  s_ARVALID_o,
    input  logic                                  s_ARREADY_i,
    output logic [MST_ID_W-1:0]                   ord_mst_o,
    output logic [TRANS_DATA_LEN_W-1:0]           ord_len_o,
    output logic                                  ord_valid_o,
    input  logic                                  ord_pop_i
);
    typedef struct packed {
        logic [MST_ID_W-1:0]          mst;
        logic [TRANS_MST_ID_W-1:0]    id;
        logic [ADDR_WIDTH-1:0]        addr;
        logic [TRANS_BURST_W-1:0]     burst;
        logic [TRANS_DATA_LEN_W-1:0]  len;
        logic [TRANS_DATA_SIZE_W-1:0] size;
    } ar_t;

    typedef struct packed {
        logic [MST_ID_W-1:0]         mst;
        logic [TRANS_DATA_LEN_W-1:0] len;
    } ord_t;

    logic [MST_ID_W-1:0] rr_ptr;
    logic [MST_ID_W-1:0] gnt_idx;
    logic [MST_ID_W:0]   scan_sum;
    logic [MST_ID_W-1:0] scan_idx;
    logic                gnt_found;
    logic                slot_free;
    logic                fifo_full;
    logic                accept;
    ar_t                 gnt_ar;
    ar_t                 ar_q;
    logic                ar_vld_q;
    ord_t                ord_push_dat;
    ord_t                ord_head;

    // The output register can take a new request when empty or when it drains this cycle.
    assign slot_free = ~ar_vld_q | s_ARREADY_i;
    assign accept    = gnt_found & slot_free & ~fifo_full;

    // Round-robin scan: first valid master starting at rr_ptr, wrapping modulo MST_AMT.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int i = 0; i < MST_AMT; i++) begin
            scan_sum = {1'b0, rr_ptr} + (MST_ID_W + 1)'(i);
            if (scan_sum >= (MST_ID_W + 1)'(MST_AMT)) begin
                scan_sum = scan_sum - (MST_ID_W + 1)'(MST_AMT);
            end
            scan_idx = scan_sum[MST_ID_W-1:0];
            if (!gnt_found && dsp_ARVALID_i[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    // Payload mux for the selected master's slice.
    always_comb begin
        gnt_ar       = '0;
        gnt_ar.mst   = gnt_idx;
        gnt_ar.id    = dsp_ARID_i[gnt_idx*TRANS_MST_ID_W +: TRANS_MST_ID_W];
        gnt_ar.addr  = dsp_ARADDR_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        gnt_ar.burst = dsp_ARBURST_i[gnt_idx*TRANS_BURST_W +: TRANS_BURST_W];
        gnt_ar.len   = dsp_ARLEN_i[gnt_idx*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
        gnt_ar.size  = dsp_ARSIZE_i[gnt_idx*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
    end

    // One-hot accept back to the dispatchers; forced low while reset is asserted.
    always_comb begin
        dsp_ARREADY_o = '0;
        if (accept && ARESETn_i) begin
            dsp_ARREADY_o[gnt_idx] = 1'b1;
        end
    end

    // Output AR register: load on accept, clear valid on a handshake with nothing new, else hold.
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            ar_q     <= '0;
            ar_vld_q <= 1'b0;
        end else if (accept) begin
            ar_q     <= gnt_ar;
            ar_vld_q <= 1'b1;
        end else if (s_ARREADY_i) begin
            ar_vld_q <= 1'b0;
        end
    end

    // Round-robin pointer moves just past the winner, even when it was the only requester.
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (gnt_idx == MST_ID_W'(MST_AMT - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign s_ARID_o    = {ar_q.mst, ar_q.id};
    assign s_ARADDR_o  = ar_q.addr;
    assign s_ARBURST_o = ar_q.burst;
    assign s_ARLEN_o   = ar_q.len;
    assign s_ARSIZE_o  = ar_q.size;
    assign s_ARVALID_o = ar_vld_q;

    assign ord_push_dat.mst = gnt_idx;
    assign ord_push_dat.len = gnt_ar.len;

    sa_fifo #(
        .WIDTH ($bits(ord_t)),
        .DEPTH (OUTSTANDING_AMT)
    ) u_ord_fifo (
        .clk    (ACLK_i),
        .rst_n  (ARESETn_i),
        .wr_vld (accept),
        .wr_dat (ord_push_dat),
        .full   (fifo_full),
        .rd_vld (ord_valid_o),
        .rd_dat (ord_head),
        .rd_pop (ord_pop_i)
    );

    assign ord_mst_o = ord_head.mst;
    assign ord_len_o = ord_head.len;
endmodule
